// File: rtl/lreg_stack_ctrl.sv
// lreg_stack_ctrl: local-register ring sequencer for PUSH/POP and for
// register-stack overflow (spill to memory) and underflow (fill from memory).
// Owns alpha (rO ring index), gamma (rS ring index), the ring occupancy and
// the rS memory pointer.
// Optional: define LSTACK_STATS_EN to add spill_cnt/fill_cnt word counters.
module lreg_stack_ctrl #(
  parameter int RING_BITS = 8,
  parameter int ADDR_W    = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [RING_BITS:0]    cmd_n,
  input  logic [RING_BITS:0]    l_cur,
  input  logic                  rs_set,
  input  logic [ADDR_W-1:0]     rs_wdata,
  output logic                  cmd_done,
  output logic                  cmd_err,
  output logic [RING_BITS-1:0]  alpha,
  output logic [RING_BITS-1:0]  gamma,
  output logic [RING_BITS:0]    stored,
  output logic [ADDR_W-1:0]     rs,
  output logic                  rf_rd_req,
  output logic [7:0]            rf_rd_addr,
  input  logic                  rf_rd_valid,
  input  logic [63:0]           rf_rd_data,
  output logic                  rf_we,
  output logic [7:0]            rf_wa,
  output logic [63:0]           rf_wd,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [63:0]           mem_wdata,
  input  logic                  mem_ack,
  input  logic [63:0]           mem_rdata
`ifdef LSTACK_STATS_EN
  ,
  output logic [31:0]           spill_cnt,
  output logic [31:0]           fill_cnt
`endif
);

  localparam int CW = RING_BITS + 2;
  localparam logic [CW-1:0]        RING_W = CW'(1 << RING_BITS);
  localparam logic [RING_BITS-1:0] R_ONE  = 1;
  localparam logic [RING_BITS:0]   S_ONE  = 1;
  localparam logic [ADDR_W-1:0]    OCT    = 8;

  localparam logic [1:0] OP_ENSURE = 2'd1;
  localparam logic [1:0] OP_PUSH   = 2'd2;
  localparam logic [1:0] OP_POP    = 2'd3;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SP_RD = 3'd1;
  localparam logic [2:0] S_SP_WR = 3'd2;
  localparam logic [2:0] S_FL_RD = 3'd3;
  localparam logic [2:0] S_FL_WR = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]           state_q, state_d;
  logic [RING_BITS-1:0] alpha_q, alpha_d, gamma_q, gamma_d;
  logic [RING_BITS:0]   stored_q, stored_d, rem_q, rem_d, popk_q, popk_d;
  logic [ADDR_W-1:0]    rs_q, rs_d;
  logic [63:0]          sbuf_q, sbuf_d;
  logic                 err_q, err_d;

  // Occupancy math is done one bit wider than the ring count so that
  // RING - stored - l_cur and n - free never wrap.
  logic [CW-1:0] st_w, l_w, n_w, free_w, need_w, pop_lim_w;
  assign st_w      = {1'b0, stored_q};
  assign l_w       = {1'b0, l_cur};
  assign n_w       = {1'b0, cmd_n};
  assign free_w    = RING_W - st_w - l_w;
  assign need_w    = n_w - free_w;
  assign pop_lim_w = RING_W - l_w;

  // Next-state: command decode in IDLE, one word per SP/FL round trip.
  always_comb begin
    state_d  = state_q;
    alpha_d  = alpha_q;
    gamma_d  = gamma_q;
    stored_d = stored_q;
    rem_d    = rem_q;
    popk_d   = popk_q;
    rs_d     = rs_q;
    sbuf_d   = sbuf_q;
    err_d    = err_q;
    unique case (state_q)
      S_IDLE: begin
        // rS load lands in the same cycle, so a concurrent command sees it.
        if (rs_set) rs_d = {rs_wdata[ADDR_W-1:3], 3'b000};
        if (cmd_valid) begin
          err_d   = 1'b0;
          state_d = S_DONE;
          unique case (cmd_op)
            OP_ENSURE: begin
              if (n_w > free_w) begin
                if (st_w >= need_w) begin
                  rem_d   = need_w[RING_BITS:0];
                  state_d = S_SP_RD;
                end else begin
                  err_d = 1'b1;
                end
              end
            end
            OP_PUSH: begin
              if (n_w > free_w) begin
                err_d = 1'b1;
              end else begin
                alpha_d  = alpha_q + cmd_n[RING_BITS-1:0];
                stored_d = stored_q + cmd_n;
              end
            end
            OP_POP: begin
              if (n_w > pop_lim_w) begin
                err_d = 1'b1;
              end else if (cmd_n <= stored_q) begin
                alpha_d  = alpha_q - cmd_n[RING_BITS-1:0];
                stored_d = stored_q - cmd_n;
              end else begin
                rem_d   = cmd_n - stored_q;
                popk_d  = cmd_n;
                state_d = S_FL_RD;
              end
            end
            default: ;
          endcase
        end
      end
      S_SP_RD: begin
        if (rf_rd_valid) begin
          sbuf_d  = rf_rd_data;
          state_d = S_SP_WR;
        end
      end
      S_SP_WR: begin
        if (mem_ack) begin
          gamma_d  = gamma_q + R_ONE;
          rs_d     = rs_q + OCT;
          stored_d = stored_q - S_ONE;
          rem_d    = rem_q - S_ONE;
          state_d  = (rem_q == S_ONE) ? S_DONE : S_SP_RD;
        end
      end
      S_FL_RD: begin
        if (mem_ack) begin
          sbuf_d  = mem_rdata;
          state_d = S_FL_WR;
        end
      end
      S_FL_WR: begin
        gamma_d = gamma_q - R_ONE;
        rs_d    = rs_q - OCT;
        rem_d   = rem_q - S_ONE;
        if (rem_q == S_ONE) begin
          // Last fill: the deferred pop is applied against post-fill stored.
          alpha_d  = alpha_q - popk_q[RING_BITS-1:0];
          stored_d = stored_q + S_ONE - popk_q;
          state_d  = S_DONE;
        end else begin
          stored_d = stored_q + S_ONE;
          state_d  = S_FL_RD;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and pointer registers; reset aborts any in-flight transfer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      alpha_q  <= '0;
      gamma_q  <= '0;
      stored_q <= '0;
      rem_q    <= '0;
      popk_q   <= '0;
      rs_q     <= '0;
      sbuf_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      alpha_q  <= alpha_d;
      gamma_q  <= gamma_d;
      stored_q <= stored_d;
      rem_q    <= rem_d;
      popk_q   <= popk_d;
      rs_q     <= rs_d;
      sbuf_q   <= sbuf_d;
      err_q    <= err_d;
    end
  end

  assign cmd_ready  = (state_q == S_IDLE);
  assign cmd_done   = (state_q == S_DONE);
  assign cmd_err    = (state_q == S_DONE) && err_q;
  assign alpha      = alpha_q;
  assign gamma      = gamma_q;
  assign stored     = stored_q;
  assign rs         = rs_q;
  assign rf_rd_req  = (state_q == S_SP_RD);
  assign rf_rd_addr = 8'(gamma_q);
  assign rf_we      = (state_q == S_FL_WR);
  assign rf_wa      = rf_we ? 8'(gamma_q - R_ONE) : 8'd0;
  assign rf_wd      = sbuf_q;
  assign mem_req    = (state_q == S_SP_WR) || (state_q == S_FL_RD);
  assign mem_we     = (state_q == S_SP_WR);
  assign mem_addr   = (state_q == S_FL_RD) ? (rs_q - OCT) : rs_q;
  assign mem_wdata  = sbuf_q;

`ifdef LSTACK_STATS_EN
  logic [31:0] spill_q, fill_q;

  // Completed-word counters, free-running with natural 32-bit wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      spill_q <= '0;
      fill_q  <= '0;
    end else begin
      if (state_q == S_SP_WR && mem_ack) spill_q <= spill_q + 32'd1;
      if (state_q == S_FL_WR)            fill_q  <= fill_q + 32'd1;
    end
  end

  assign spill_cnt = spill_q;
  assign fill_cnt  = fill_q;
`endif

endmodule
